capsense_scan_ctrl: RTL
=======================

CAPSENSE_SCAN_CTRL -- requirements
Module: capsense_scan_ctrl

Interface
REQ-001 SHALL have parameter NumSense, default 4, number of capacitive sensor inputs sharing one charge-out pin.
REQ-002 SHALL have parameter CountWidth, default 16, width of each per-sensor count.
REQ-003 SHALL have parameter DischargeCycles, default 1024, length of the discharge phase in clk cycles (≥1).
REQ-004 SHALL have parameter TimeoutCycles, default 4095, maximum length of the charge phase in clk cycles (1..2^CountWidth-1).
REQ-005 SHALL have port clk  input  1  the single block clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  1 = run continuous scans.
REQ-008 SHALL have port threshold  input  CountWidth  touch-decision threshold.
REQ-009 SHALL have port sense_in  input  NumSense  raw sensor pin levels, asynchronous to clk.
REQ-010 SHALL have port charge_out  output  1  drive level for the shared charge pin.
REQ-011 SHALL have port sense_count  output  NumSense*CountWidth  last completed counts; sensor i in bits [i*CountWidth +: CountWidth].
REQ-012 SHALL have port touched  output  NumSense  per-sensor touch flag.
REQ-013 SHALL have port scan_done  output  1  one-cycle pulse when sense_count/touched update.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL pass sense_in through a 2-flop synchronizer; all decisions use the synchronized bits; no latency compensation is applied to counts.
REQ-016 SHALL implement FSM states IDLE, DISCHARGE, CHARGE, UPDATE.
REQ-017 IDLE: charge_out=0; enable=1 -> DISCHARGE next cycle with phase timer cleared.
REQ-018 DISCHARGE: charge_out=0 for exactly DischargeCycles cycles, then -> CHARGE with timer=0 and all per-sensor captured flags cleared.
REQ-019 CHARGE: charge_out=1; the timer increments by 1 per cycle starting at 0 on the first CHARGE cycle.
REQ-020 CHARGE: in any cycle where synced bit i=1 and sensor i is not yet captured, the current timer value SHALL be stored as pending count i and sensor i marked captured; later transitions are ignored.
REQ-021 CHARGE exits to UPDATE after the cycle in which all sensors are captured, or after the cycle with timer = TimeoutCycles-1, whichever is first; uncaptured sensors get pending count = TimeoutCycles.
REQ-022 Capture and timeout in the same cycle: the captured timer value wins for that sensor.
REQ-023 UPDATE (one cycle): sense_count <= pending counts; touched[i] <= (pending i > threshold), threshold sampled in this cycle; scan_done=1 for this cycle only.
REQ-024 UPDATE -> DISCHARGE if enable=1, else -> IDLE.
REQ-025 enable is sampled only in IDLE and UPDATE; deassertion mid-scan lets the current scan complete, including its UPDATE.
REQ-026 sense_count and touched hold their values between UPDATE cycles, including in IDLE.
REQ-027 Timer and count arithmetic is unsigned CountWidth; the timer never exceeds TimeoutCycles, so no wrap occurs.
REQ-028 busy is combinationally derived from state (state != IDLE).

Reset
REQ-029 reset=1 SHALL asynchronously force state IDLE, charge_out=0, sense_count=0, touched=0, scan_done=0, busy=0, and clear timer, pending counts, captured flags and synchronizer flops.
REQ-030 Reset asserted mid-scan SHALL abort the scan without a scan_done pulse; scanning resumes after release only if enable=1 in IDLE.

Verification
(bench parameters: NumSense=4, CountWidth=16, DischargeCycles=8, TimeoutCycles=100)
REQ-031 Reset, then enable=0 for 50 cycles -> all outputs 0, busy=0.
REQ-032 enable=1, threshold=50; sensor0 raw rises 10 cycles after charge_out rises, sensors1-3 raw rise at 3, 20, 60 -> counts 12, 5, 22, 62; touched=4'b1000; one scan_done pulse.
REQ-033 Sensor2 raw held low -> sense_count[2]=100, touched[2]=1; CHARGE lasts exactly 100 cycles.
REQ-034 All sense_in held high from reset -> all counts 0, touched=0; CHARGE lasts 1 cycle; scan period = 8+1+1 cycles after the first IDLE exit.
REQ-035 reset pulsed 30 cycles into CHARGE -> charge_out=0 immediately, counts 0, no scan_done; with enable=1, DISCHARGE restarts one cycle after release.
REQ-036 enable dropped in the middle of DISCHARGE -> scan completes, scan_done pulses, then IDLE with busy=0 and counts retained.

Source files
------------

// File: rtl/capsense_scan_ctrl.sv
// Capacitive-sense scan controller.
// Repeatedly discharges a shared charge pin, then drives it high and times how
// long each sensor input takes to read high. The per-sensor charge times are
// published together with a per-sensor touch decision once per scan.
//
// Ports:
//   clk          block clock, rising-edge active
//   reset        asynchronous active-high reset
//   enable       1 = run continuous scans
//   threshold    touch-decision threshold (count > threshold => touched)
//   sense_in     raw sensor pin levels, asynchronous to clk
//   charge_out   drive level for the shared charge pin
//   sense_count  last completed counts, sensor i at [i*CountWidth +: CountWidth]
//   touched      per-sensor touch flags from the last completed scan
//   scan_done    one-cycle pulse while the published results are being updated
//   busy         high whenever the controller is not idle
module capsense_scan_ctrl #(
  parameter int unsigned NumSense        = 4,
  parameter int unsigned CountWidth      = 16,
  parameter int unsigned DischargeCycles = 1024,
  parameter int unsigned TimeoutCycles   = 4095
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [CountWidth-1:0]          threshold,
  input  logic [NumSense-1:0]            sense_in,
  output logic                           charge_out,
  output logic [NumSense*CountWidth-1:0] sense_count,
  output logic [NumSense-1:0]            touched,
  output logic                           scan_done,
  output logic                           busy
);

  // One phase timer serves both discharge and charge, so it must hold the
  // larger of the two terminal values.
  localparam int unsigned DisWidth   = $clog2(DischargeCycles + 1);
  localparam int unsigned TimerWidth = (DisWidth > CountWidth) ? DisWidth : CountWidth;

  localparam logic [TimerWidth-1:0] DisLast      = TimerWidth'(DischargeCycles - 1);
  localparam logic [TimerWidth-1:0] ChgLast      = TimerWidth'(TimeoutCycles - 1);
  localparam logic [CountWidth-1:0] TimeoutCount = CountWidth'(TimeoutCycles);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISCHARGE = 2'd1,
    CHARGE    = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  state_t state, next_state;

  logic [TimerWidth-1:0]                timer_q, timer_d;
  logic [NumSense-1:0]                  captured_q, captured_d;
  logic [NumSense-1:0][CountWidth-1:0]  pending_q, pending_d;
  logic [NumSense-1:0]                  sync_q1, sync_q2;
  logic [NumSense-1:0]                  touched_d;

  // Two-flop synchronizer for the asynchronous sensor pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= sense_in;
      sync_q2 <= sync_q1;
    end
  end

  // State, timer and capture bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer_q    <= '0;
      captured_q <= '0;
      pending_q  <= '0;
    end else begin
      state      <= next_state;
      timer_q    <= timer_d;
      captured_q <= captured_d;
      pending_q  <= pending_d;
    end
  end

  // Next-state, timer and capture logic.
  always_comb begin
    next_state = state;
    timer_d    = timer_q;
    captured_d = captured_q;
    pending_d  = pending_q;

    unique case (state)
      IDLE: begin
        if (enable) begin
          next_state = DISCHARGE;
          timer_d    = '0;
        end
      end

      DISCHARGE: begin
        if (timer_q == DisLast) begin
          next_state = CHARGE;
          timer_d    = '0;
          captured_d = '0;
        end else begin
          timer_d = timer_q + TimerWidth'(1);
        end
      end

      CHARGE: begin
        // First high reading latches the current timer; later edges are ignored.
        for (int i = 0; i < NumSense; i++) begin
          if (sync_q2[i] && !captured_q[i]) begin
            pending_d[i]  = CountWidth'(timer_q);
            captured_d[i] = 1'b1;
          end
        end
        if ((&captured_d) || (timer_q == ChgLast)) begin
          next_state = UPDATE;
          // A capture in the timeout cycle was already stored above and wins.
          for (int i = 0; i < NumSense; i++) begin
            if (!captured_d[i]) begin
              pending_d[i] = TimeoutCount;
            end
          end
        end else begin
          timer_d = timer_q + TimerWidth'(1);
        end
      end

      UPDATE: begin
        next_state = enable ? DISCHARGE : IDLE;
        timer_d    = '0;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Touch decision against the threshold presented during UPDATE.
  always_comb begin
    touched_d = '0;
    for (int i = 0; i < NumSense; i++) begin
      touched_d[i] = (pending_q[i] > threshold);
    end
  end

  // Registered outputs; charge_out and scan_done track the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      charge_out  <= 1'b0;
      scan_done   <= 1'b0;
      sense_count <= '0;
      touched     <= '0;
    end else begin
      charge_out <= (next_state == CHARGE);
      scan_done  <= (next_state == UPDATE);
      if (state == UPDATE) begin
        sense_count <= pending_q;
        touched     <= touched_d;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
